mt_sequencer: RTL and testbench

- Generates the one-hot machine-cycle (M1..M6) and T-state (T1..T6) timing vectors consumed by the execute stage.
- Closes the loop with execute: consumes its nextM/setM1 requests and advances the timing state.
- Applies WAIT stretching and bus-request holds.
- Sits between the pin-level bus control and pla_decode/execute inside the control unit.

---
 rtl/mt_sequencer_pkg.sv | 26 ++
 rtl/mt_sequencer_onehot_rotate6.sv | 25 ++
 rtl/mt_sequencer.sv | 85 ++++++++
 tb/tb_mt_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mt_sequencer_pkg.sv
// Shared timing-vector types and bit positions for the M/T sequencer and execute.
package mt_sequencer_pkg;

    localparam int SEQ_W = 6;

    typedef logic [SEQ_W-1:0] m_vec_t;
    typedef logic [SEQ_W-1:0] t_vec_t;

    localparam m_vec_t M_RESET = 6'b000001;
    localparam t_vec_t T_RESET = 6'b000001;

    localparam int M1_IDX = 0;
    localparam int M2_IDX = 1;
    localparam int M3_IDX = 2;
    localparam int M4_IDX = 3;
    localparam int M5_IDX = 4;
    localparam int M6_IDX = 5;

    localparam int T1_IDX = 0;
    localparam int T2_IDX = 1;
    localparam int T3_IDX = 2;
    localparam int T4_IDX = 3;
    localparam int T5_IDX = 4;
    localparam int T6_IDX = 5;

endpackage

// File: rtl/mt_sequencer_onehot_rotate6.sv
// Six-bit one-hot rotating register; load returns to bit 0 and beats shift.
module onehot_rotate6
    import mt_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    output logic [SEQ_W-1:0] q,
    output logic             wrap
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= 6'b000001;
        else if (load)
            q <= 6'b000001;
        else if (shift)
            q <= {q[SEQ_W-2:0], q[SEQ_W-1]};
    end

    // A shift from the top bit rolls back to bit 0.
    assign wrap = q[SEQ_W-1];

endmodule

// File: rtl/mt_sequencer.sv
// Machine-cycle / T-state timing generator with WAIT stretching and bus-request parking.
module mt_sequencer
    import mt_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic nextM,
    input  logic setM1,
    input  logic hold_wait,
    input  logic hold_busrq,
    output logic M1,
    output logic M2,
    output logic M3,
    output logic M4,
    output logic M5,
    output logic M6,
    output logic T1,
    output logic T2,
    output logic T3,
    output logic T4,
    output logic T5,
    output logic T6,
    output logic timings_en,
    output logic busack,
    output logic seq_err
);

    m_vec_t m_q;
    t_vec_t t_q;
    logic   m_wrap, t_wrap;
    logic   busack_q, seq_err_q;
    logic   req, wait_frz, bus_entry, adv;
    logic   m_load, m_shift, t_load, t_shift;
    logic   seq_err_d, busack_d;

    assign req       = nextM | setM1;
    assign wait_frz  = t_q[T2_IDX] & hold_wait & ~busack_q;
    assign bus_entry = ~busack_q & req & hold_busrq;

    // Bus-hold entry outranks WAIT, so the boundary action still lands.
    assign adv = ~busack_q & (~wait_frz | bus_entry);

    assign m_load  = adv & (setM1 | (nextM & m_wrap));
    assign m_shift = adv & nextM & ~setM1 & ~m_wrap;
    assign t_load  = adv & req;
    assign t_shift = adv & ~req;

    assign seq_err_d = adv & ((nextM & ~setM1 & m_wrap) | (~req & t_wrap));
    assign busack_d  = busack_q ? hold_busrq : bus_entry;

    onehot_rotate6 u_m (
        .clk   (clk),
        .rst   (reset),
        .load  (m_load),
        .shift (m_shift),
        .q     (m_q),
        .wrap  (m_wrap)
    );

    onehot_rotate6 u_t (
        .clk   (clk),
        .rst   (reset),
        .load  (t_load),
        .shift (t_shift),
        .q     (t_q),
        .wrap  (t_wrap)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busack_q  <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            busack_q  <= busack_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign {M6, M5, M4, M3, M2, M1} = m_q;
    assign {T6, T5, T4, T3, T2, T1} = t_q;
    assign timings_en = ~(busack_q | (t_q[T2_IDX] & hold_wait));
    assign busack     = busack_q;
    assign seq_err    = seq_err_q;

endmodule

// File: tb/tb_mt_sequencer.sv
// Directed bench for mt_sequencer: free run, M transitions, WAIT, BUSRQ, async reset.
module tb_mt_sequencer;

    logic clk = 1'b0;
    logic reset, nextM, setM1, hold_wait, hold_busrq;
    logic M1, M2, M3, M4, M5, M6, T1, T2, T3, T4, T5, T6;
    logic timings_en, busack, seq_err;
    logic [5:0] m, t;
    int chk_cnt = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    assign m = {M6, M5, M4, M3, M2, M1};
    assign t = {T6, T5, T4, T3, T2, T1};

    mt_sequencer dut (
        .clk(clk), .reset(reset), .nextM(nextM), .setM1(setM1),
        .hold_wait(hold_wait), .hold_busrq(hold_busrq),
        .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
        .T1(T1), .T2(T2), .T3(T3), .T4(T4), .T5(T5), .T6(T6),
        .timings_en(timings_en), .busack(busack), .seq_err(seq_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nextM = 0; setM1 = 0; hold_wait = 0; hold_busrq = 0;
        reset = 1;
        step();
        reset = 0;
    endtask

    task automatic test_reset();
        nextM = 0; setM1 = 0; hold_wait = 0; hold_busrq = 0;
        reset = 1;
        #2;
        chk_cnt++;
        if ({m, t, timings_en, busack, seq_err} !== {6'b000001, 6'b000001, 3'b100}) begin
            $display("FAIL reset: m=%b t=%b en=%b ack=%b err=%b want m=000001 t=000001 en=1 ack=0 err=0",
                     m, t, timings_en, busack, seq_err);
        end else pass_cnt++;
        step();
        reset = 0;
    endtask

    task automatic test_free_run();
        logic [5:0] exp_t;
        do_reset();
        for (int k = 1; k <= 7; k++) begin
            step();
            exp_t = 6'b000001 << (k % 6);
            chk_cnt++;
            if ({m, t, seq_err} !== {6'b000001, exp_t, (k == 6)}) begin
                $display("FAIL free_run[%0d]: m=%b t=%b err=%b want m=000001 t=%b err=%b",
                         k, m, t, seq_err, exp_t, (k == 6));
            end else pass_cnt++;
        end
    endtask

    task automatic test_m_transitions();
        logic [1:0]  req [8]  = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00};
        logic [5:0]  em  [8]  = '{6'd1, 6'd1, 6'd1, 6'd2, 6'd2, 6'd2, 6'd1, 6'd1};
        logic [5:0]  et  [8]  = '{6'd2, 6'd4, 6'd8, 6'd1, 6'd2, 6'd4, 6'd1, 6'd2};
        do_reset();
        for (int k = 0; k < 8; k++) begin
            {nextM, setM1} = req[k];
            step();
            chk_cnt++;
            if ({m, t, seq_err} !== {em[k], et[k], 1'b0}) begin
                $display("FAIL m_trans[%0d]: m=%b t=%b err=%b want m=%b t=%b err=0",
                         k, m, t, seq_err, em[k], et[k]);
            end else pass_cnt++;
        end
        nextM = 0; setM1 = 0;
    endtask

    task automatic test_wait();
        do_reset();
        step();
        hold_wait = 1;
        #1;
        chk_cnt++;
        if (timings_en !== 1'b0) $display("FAIL wait_en_t2: en=%b want 0", timings_en);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_cnt++;
            if ({m, t, timings_en} !== {6'd1, 6'd2, 1'b0})
                $display("FAIL wait_hold[%0d]: m=%b t=%b en=%b want m=000001 t=000010 en=0",
                         k, m, t, timings_en);
            else pass_cnt++;
        end
        hold_wait = 0;
        step();
        chk_cnt++;
        if ({m, t, timings_en} !== {6'd1, 6'd4, 1'b1})
            $display("FAIL wait_release: m=%b t=%b en=%b want m=000001 t=000100 en=1", m, t, timings_en);
        else pass_cnt++;
        hold_wait = 1;
        #1;
        chk_cnt++;
        if (timings_en !== 1'b1) $display("FAIL wait_t3_en: en=%b want 1", timings_en);
        else pass_cnt++;
        step();
        chk_cnt++;
        if (t !== 6'd8) $display("FAIL wait_t3_adv: t=%b want 001000", t);
        else pass_cnt++;
        hold_wait = 0;
    endtask

    task automatic test_busrq();
        do_reset();
        step(); step(); step();
        setM1 = 1; hold_busrq = 1;
        step();
        setM1 = 0;
        chk_cnt++;
        if ({m, t, busack, timings_en} !== {6'd1, 6'd1, 2'b10})
            $display("FAIL busrq_entry: m=%b t=%b ack=%b en=%b want m=000001 t=000001 ack=1 en=0",
                     m, t, busack, timings_en);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_cnt++;
            if ({m, t, busack, timings_en} !== {6'd1, 6'd1, 2'b10})
                $display("FAIL busrq_hold[%0d]: m=%b t=%b ack=%b en=%b want m=000001 t=000001 ack=1 en=0",
                         k, m, t, busack, timings_en);
            else pass_cnt++;
        end
        hold_busrq = 0;
        step();
        chk_cnt++;
        if ({m, t, busack, timings_en} !== {6'd1, 6'd1, 2'b01})
            $display("FAIL busrq_release: m=%b t=%b ack=%b en=%b want m=000001 t=000001 ack=0 en=1",
                     m, t, busack, timings_en);
        else pass_cnt++;
        step();
        chk_cnt++;
        if ({m, t} !== {6'd1, 6'd2})
            $display("FAIL busrq_resume: m=%b t=%b want m=000001 t=000010", m, t);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_m;
        do_reset();
        step();
        nextM = 1; setM1 = 1;
        step();
        setM1 = 0;
        chk_cnt++;
        if ({m, t} !== {6'd1, 6'd1})
            $display("FAIL both_req: m=%b t=%b want m=000001 t=000001", m, t);
        else pass_cnt++;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp_m = 6'b000001 << (k % 6);
            chk_cnt++;
            if ({m, t, seq_err} !== {exp_m, 6'd1, (k == 6)})
                $display("FAIL nextm_chain[%0d]: m=%b t=%b err=%b want m=%b t=000001 err=%b",
                         k, m, t, seq_err, exp_m, (k == 6));
            else pass_cnt++;
        end
        nextM = 0;
        step();
        chk_cnt++;
        if ({m, t, seq_err} !== {6'd1, 6'd2, 1'b0})
            $display("FAIL nextm_after: m=%b t=%b err=%b want m=000001 t=000010 err=0", m, t, seq_err);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        do_reset();
        step();
        hold_wait = 1;
        step();
        #2 reset = 1;
        #1;
        chk_cnt++;
        if ({m, t, busack} !== {6'd1, 6'd1, 1'b0})
            $display("FAIL async_wait: m=%b t=%b ack=%b want m=000001 t=000001 ack=0", m, t, busack);
        else pass_cnt++;
        #1 reset = 0; hold_wait = 0;
        step();
        nextM = 1; hold_busrq = 1;
        step();
        nextM = 0;
        chk_cnt++;
        if ({m, t, busack} !== {6'd2, 6'd1, 1'b1})
            $display("FAIL async_pre: m=%b t=%b ack=%b want m=000010 t=000001 ack=1", m, t, busack);
        else pass_cnt++;
        step();
        #2 reset = 1;
        #1;
        chk_cnt++;
        if ({m, t, busack, timings_en} !== {6'd1, 6'd1, 2'b01})
            $display("FAIL async_busrq: m=%b t=%b ack=%b en=%b want m=000001 t=000001 ack=0 en=1",
                     m, t, busack, timings_en);
        else pass_cnt++;
        #1 reset = 0; hold_busrq = 0;
        step();
    endtask

    initial begin
        reset = 1; nextM = 0; setM1 = 0; hold_wait = 0; hold_busrq = 0;
        test_reset();
        test_free_run();
        test_m_transitions();
        test_wait();
        test_busrq();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
